ascii_to_b7: RTL and testbench
==============================

ASCII_TO_B7 -- requirements
Module: ascii_to_b7

Interface
REQ-001 Parameter WIDTH, default 7, character width in bits; the block SHALL support only WIDTH = 7.
REQ-002 Parameter IDLE_LEVEL, default 1'b0, level driven on sout while no frame is active.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 din  input  WIDTH  parallel ASCII character to transmit.
REQ-006 load  input  1  request to transmit din; sampled on the rising edge.
REQ-007 ready  output  1  block accepts load this cycle.
REQ-008 sout  output  1  serial data, MSB first, one bit per clk.
REQ-009 on  output  1  high while sout carries a frame bit.
REQ-010 done  output  1  one-cycle pulse in the cycle that drives the last frame bit.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE, ready=1, on=0, done=0 and sout=IDLE_LEVEL.
REQ-013 On load=1 && ready=1, the block SHALL capture din into a shift register and enter SHIFT with bit counter = 0.
REQ-014 Latency: the first data bit (din[6]) SHALL appear on sout in the cycle after the accepting edge.
REQ-015 In SHIFT, sout SHALL equal the register MSB; each edge SHALL shift the register left by one and increment the counter.
REQ-016 A frame SHALL be exactly FRAME_LEN consecutive cycles with on=1, in the order din[6] down to din[0].
REQ-017 ready SHALL be 1 in the last frame cycle (counter = FRAME_LEN-1), and 0 in all other SHIFT cycles.
REQ-018 load=1 in the last frame cycle SHALL start the next frame on the following cycle with no gap: on stays 1 and the counter restarts at 0.
REQ-019 load=0 in the last frame cycle SHALL return the FSM to IDLE.
REQ-020 load while ready=0 SHALL be ignored; changes to din after acceptance SHALL NOT affect the frame in flight.
REQ-021 done SHALL be 1 only when on=1 and counter = FRAME_LEN-1.
REQ-022 The counter SHALL be 3 bits, SHALL never exceed FRAME_LEN-1, and SHALL wrap to 0 only on frame end.

Reset
REQ-023 While rst=0: state=IDLE, counter=0, shift register=0, sout=IDLE_LEVEL, on=0, done=0, ready=0.
REQ-024 ready SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with no partial bits after deassertion.

Configuration
REQ-026 Macro ASCII_TX_PARITY_EN defined: an even-parity bit (XOR of din[6:0]) SHALL follow din[0], giving FRAME_LEN = 8.
REQ-027 Macro ASCII_TX_PARITY_EN undefined: FRAME_LEN = 7 and no parity logic SHALL be synthesized.

Structure
REQ-028 The shared package b7_pkg SHALL hold B7_WIDTH = 7, the FRAME_LEN derivation and the state enum {IDLE, SHIFT}; the matching receiver SHALL use the same package.
REQ-029 One sub-module b7_piso SHALL implement the load/shift register and bit counter; the FSM and flags SHALL live in ascii_to_b7.

Verification
REQ-030 Reset, then load=1 with din=7'h41 for 1 cycle -> sout = 1,0,0,0,0,0,1 over 7 cycles; on=1 for exactly those cycles; done only on the 7th; then IDLE.
REQ-031 din=7'h41 then 7'h7A, with load held in the last cycle -> 14 contiguous on cycles; sout = 1000001 then 1111010; no idle gap.
REQ-032 load pulses during bits 2-5, and din toggled mid-frame -> frame unchanged; ready=0 throughout.
REQ-033 rst=0 at bit 3 of 7'h55 -> all outputs at reset values immediately; after release ready=1 and no residual bits.
REQ-034 ASCII_TX_PARITY_EN defined, din=7'h41 -> 8-bit frame 1,0,0,0,0,0,1,0; done on the 8th cycle.
REQ-035 Loopback into the matching b7 deserializer, sending all 128 codes back-to-back -> every received character equals the one sent.

Source files
------------

// File: rtl/b7_pkg.sv
// b7_pkg: shared definitions for the 7-bit ASCII serial link (tx and rx).
// Holds char width, frame length, FSM state enum and the frame builder.
// Config macro: ASCII_TX_PARITY_EN appends an even-parity bit to each frame.
package b7_pkg;

    localparam int B7_WIDTH = 7;

`ifdef ASCII_TX_PARITY_EN
    localparam int FRAME_LEN = B7_WIDTH + 1;
`else
    localparam int FRAME_LEN = B7_WIDTH;
`endif

    localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 1);
    localparam logic [2:0] PEN_BIT  = 3'(FRAME_LEN - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } b7_state_e;

    // Frame bits, MSB is sent first: char bits 6..0 then optional parity.
    function automatic logic [FRAME_LEN-1:0] b7_frame(
        input logic [B7_WIDTH-1:0] c
    );
`ifdef ASCII_TX_PARITY_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/ascii_to_b7_if.sv
// ascii_to_b7_if: parallel-load / serial-out bus of the b7 transmitter.
// master drives din/load; slave returns ready, sout, on, done.
interface ascii_to_b7_if
    import b7_pkg::*;
#(
    parameter int WIDTH = B7_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             sout;
    logic             on;
    logic             done;

    modport master (
        output din, load,
        input  ready, sout, on, done
    );

    modport slave (
        input  din, load,
        output ready, sout, on, done
    );
endinterface

// File: rtl/b7_piso.sv
// b7_piso: frame shift register and bit counter of the b7 transmitter.
// Ports: clk, rst (async low), ld/frame (parallel load), sh (shift), msb, cnt.
module b7_piso
    import b7_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic                 sh,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 msb,
    output logic [2:0]           cnt
);
    logic [FRAME_LEN-1:0] sreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (ld) begin
            sreg <= frame;
            cnt  <= '0;
        end else if (sh) begin
            sreg <= {sreg[FRAME_LEN-2:0], 1'b0};
            // Counter only wraps when the frame ends.
            cnt  <= (cnt == LAST_BIT) ? 3'd0 : cnt + 3'd1;
        end
    end

    assign msb = sreg[FRAME_LEN-1];

endmodule

// File: rtl/ascii_to_b7.sv
// ascii_to_b7: 7-bit ASCII parallel-to-serial transmitter, MSB first.
// Ports: clk, rst (async low), bus (ascii_to_b7_if.slave: din, load,
// ready, sout, on, done). Macro ASCII_TX_PARITY_EN adds an even-parity bit.
module ascii_to_b7
    import b7_pkg::*;
#(
    parameter int   WIDTH      = 7,
    parameter logic IDLE_LEVEL = 1'b0
)(
    input  logic             clk,
    input  logic             rst,
    ascii_to_b7_if.slave     bus
);
    b7_state_e            state;
    logic                 on_r;
    logic                 done_r;
    logic                 ready_r;
    logic                 acc;
    logic                 sh;
    logic                 msb;
    logic [2:0]           cnt;
    logic [WIDTH-1:0]     din_w;
    logic [FRAME_LEN-1:0] frame;

    assign din_w = bus.din;
    assign frame = b7_frame(din_w);
    assign acc   = bus.load & ready_r;
    assign sh    = (state == SHIFT) & ~acc;

    b7_piso u_piso (
        .clk   (clk),
        .rst   (rst),
        .ld    (acc),
        .sh    (sh),
        .frame (frame),
        .msb   (msb),
        .cnt   (cnt)
    );

    // ready is registered so it stays low through reset and rises on
    // the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            on_r    <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else if (acc) begin
            state   <= SHIFT;
            on_r    <= 1'b1;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    on_r    <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        state   <= IDLE;
                        on_r    <= 1'b0;
                        done_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        on_r    <= 1'b1;
                        done_r  <= (cnt == PEN_BIT);
                        ready_r <= (cnt == PEN_BIT);
                    end
                end
            endcase
        end
    end

    assign bus.sout  = on_r ? msb : IDLE_LEVEL;
    assign bus.on    = on_r;
    assign bus.done  = done_r;
    assign bus.ready = ready_r;

endmodule

// File: tb/tb_ascii_to_b7.sv
// tb_ascii_to_b7: self-checking bench for ascii_to_b7 (queue-based model,
// directed table, reset abort, random traffic, 128-code loopback receiver).
module tb_ascii_to_b7;

    localparam logic IDLE_LEVEL = 1'b0;
`ifdef ASCII_TX_PARITY_EN
    localparam int FL = 8;
    localparam logic [FL-1:0] F41 = 8'b1000_0010;
    localparam logic [FL-1:0] F7A = 8'b1111_0101;
`else
    localparam int FL = 7;
    localparam logic [FL-1:0] F41 = 7'b100_0001;
    localparam logic [FL-1:0] F7A = 7'b111_1010;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ascii_to_b7_if #(.WIDTH(7)) bus ();

    ascii_to_b7 #(
        .WIDTH      (7),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       ld;
        logic [6:0] d;
        logic       e_sout;
        logic       e_on;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t tv[$];

    int checks = 0;
    int errors = 0;

    // Model: bits still to appear on sout, front = bit on the wire now.
    bit   q[$];
    bit   rdy_ok = 1'b0;
    bit   lb = 1'b0;
    bit   rxq[$];
    int   sentq[$];
    int   rx_count = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] c);
        for (int i = 6; i >= 0; i--) q.push_back(c[i]);
`ifdef ASCII_TX_PARITY_EN
        q.push_back(^c);
`endif
    endtask

    task automatic check_model();
        logic e_sout;
        e_sout = (q.size() > 0) ? q[0] : IDLE_LEVEL;
        chk("on", 32'(bus.on), 32'(q.size() > 0));
        chk("sout", 32'(bus.sout), 32'(e_sout));
        chk("done", 32'(bus.done), 32'(q.size() == 1));
        chk("ready", 32'(bus.ready), 32'(rdy_ok && q.size() <= 1));
    endtask

    task automatic rx_sample();
        logic [6:0] c;
        if (bus.on === 1'b1) rxq.push_back(bus.sout);
        if (bus.done === 1'b1) begin
            if (lb) begin
                chk("rx_len", 32'(rxq.size()), 32'(FL));
                if (rxq.size() == FL) begin
                    for (int b = 0; b < 7; b++) c[6-b] = rxq[b];
`ifdef ASCII_TX_PARITY_EN
                    chk("rx_par", 32'(rxq[7]), 32'(^c));
`endif
                    if (sentq.size() > 0)
                        chk("rx_char", 32'(c), 32'(sentq.pop_front()));
                    else
                        chk("rx_extra", 32'(c), 32'hFFFF_FFFF);
                    rx_count++;
                end
            end
            rxq.delete();
        end
    endtask

    // Called just after a falling edge: drive, predict, clock, check.
    task automatic cyc(input logic ld, input logic [6:0] d);
        bit acc;
        bus.load = ld;
        bus.din  = d;
        acc = ld && rdy_ok && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_frame(d);
        if (rst) rdy_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_model();
        rx_sample();
    endtask

    function automatic void add(input logic ld, input logic [6:0] d,
                                input logic s, input logic o,
                                input logic dn, input logic r);
        vec_t v;
        v.ld = ld; v.d = d; v.e_sout = s;
        v.e_on = o; v.e_done = dn; v.e_ready = r;
        tv.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc_ok;
        bus.load = 1'b0;
        bus.din  = '0;

        // Single 0x41 frame then idle.
        add(1'b1, 7'h41, F41[FL-1], 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < FL; i++)
            add(1'b0, 7'h3C, F41[FL-1-i], 1'b1, i == FL-1, i == FL-1);
        add(1'b0, 7'h00, IDLE_LEVEL, 1'b0, 1'b0, 1'b1);
        // 0x41 then 0x7A back-to-back.
        add(1'b1, 7'h41, F41[FL-1], 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < FL; i++)
            add(1'b0, 7'h11, F41[FL-1-i], 1'b1, i == FL-1, i == FL-1);
        add(1'b1, 7'h7A, F7A[FL-1], 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < FL; i++)
            add(1'b0, 7'h05, F7A[FL-1-i], 1'b1, i == FL-1, i == FL-1);
        add(1'b0, 7'h00, IDLE_LEVEL, 1'b0, 1'b0, 1'b1);

        // Reset state.
        @(negedge clk);
        check_model();
        @(negedge clk);
        check_model();
        rst = 1'b1;
        cyc(1'b0, 7'h00);

        foreach (tv[i]) begin
            cyc(tv[i].ld, tv[i].d);
            chk("tv_sout", 32'(bus.sout), 32'(tv[i].e_sout));
            chk("tv_on", 32'(bus.on), 32'(tv[i].e_on));
            chk("tv_done", 32'(bus.done), 32'(tv[i].e_done));
            chk("tv_ready", 32'(bus.ready), 32'(tv[i].e_ready));
        end

        // Load pulses and din churn mid-frame are ignored.
        cyc(1'b1, 7'h2A);
        for (int i = 1; i < FL; i++) begin
            cyc(i >= 2 && i <= 5, 7'($urandom));
            if (i < FL - 1) chk("busy_ready", 32'(bus.ready), 32'd0);
        end
        cyc(1'b0, 7'h00);

        // Reset mid-frame of 0x55.
        cyc(1'b1, 7'h55);
        cyc(1'b0, 7'h00);
        cyc(1'b0, 7'h00);
        #1 rst = 1'b0;
        #1;
        q.delete();
        rxq.delete();
        rdy_ok = 1'b0;
        check_model();
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 7'h13);
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        chk("post_rst_on", 32'(bus.on), 32'd0);
        cyc(1'b0, 7'h00);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 3) == 0, 7'($urandom));
        for (int n = 0; n < FL + 1; n++) cyc(1'b0, 7'h00);

        // Loopback of all 128 codes with load held.
        rxq.delete();
        lb = 1'b1;
        for (int k = 0; k < 128; k++) begin
            acc_ok = 1'b0;
            for (int t = 0; t < FL + 3 && !acc_ok; t++) begin
                acc_ok = rdy_ok && (q.size() <= 1);
                if (acc_ok) sentq.push_back(k);
                cyc(1'b1, 7'(k));
            end
            if (!acc_ok) chk("lb_accept_timeout", 32'(k), 32'hFFFF_FFFF);
        end
        for (int n = 0; n < FL + 2; n++) cyc(1'b0, 7'h00);
        lb = 1'b0;
        chk("lb_count", 32'(rx_count), 32'd128);
        chk("lb_pending", 32'(sentq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
